// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// header constants and the round-robin selection function.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    GAP,
    DONE
  } arb_state_t;

  // First set request at or after ptr, wrapping modulo n; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [IDX_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = IDX_W'((int'(ptr) + k) % n);
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = idx | IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-wide UART transmitter port: the arbiter is master, the transmitter slave.
interface uart_tx_arbiter_if;

  logic       uart_empty;
  logic       uart_tx_data_we;
  logic [7:0] uart_tx_data;

  modport master (
    input  uart_empty,
    output uart_tx_data_we,
    output uart_tx_data
  );

  modport slave (
    output uart_empty,
    input  uart_tx_data_we,
    input  uart_tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin requester pick with a registered priority pointer; the pointer
// moves just past the finishing requester when advance is pulsed.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic [N-1:0]     o_pick,
  output logic             o_any
);

  logic [IDX_W-1:0]   r_ptr;
  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick_ext;
  logic               w_unused_pick;

  always_comb begin
    w_req_ext         = '0;
    w_req_ext[N-1:0]  = i_req;
  end

  assign w_pick_ext    = rr_pick(w_req_ext, r_ptr, N);
  assign o_pick        = w_pick_ext[N-1:0];
  assign o_any         = |i_req;
  assign w_unused_pick = ^w_pick_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (int'(i_last_idx) + 1 >= N) ? '0 : i_last_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one UART byte transmitter between
// NUM_REQ sources; each packet is framed by SYNC_BYTE and the source index.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_LEN   = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   src_data,
  input  logic [NUM_REQ-1:0]     src_valid,
  input  logic [NUM_REQ-1:0]     src_last,
  output logic [NUM_REQ-1:0]     src_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   overflow,
  uart_tx_arbiter_if.master      uart
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  arb_state_t         r_state;
  arb_state_t         r_ret;
  logic [NUM_REQ-1:0] r_grant;
  logic [LEN_W-1:0]   r_len_cnt;
  logic               r_overflow;
  logic               r_we;
  logic [7:0]         r_data;
  logic               r_busy;

  arb_state_t         w_state_nxt;
  arb_state_t         w_ret_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               w_ovf_nxt;
  logic               w_we_nxt;
  logic [7:0]         w_data_nxt;
  logic               w_advance;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic [MAX_REQ-1:0] w_grant_ext;
  logic [IDX_W-1:0]   w_gidx;
  logic [7:0]         w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_accept;
  logic               w_hit_max;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (req),
    .i_advance  (w_advance),
    .i_last_idx (w_gidx),
    .o_pick     (w_pick),
    .o_any      (w_any)
  );

  always_comb begin
    w_grant_ext                = '0;
    w_grant_ext[NUM_REQ-1:0]   = r_grant;
  end

  assign w_gidx = onehot_idx(w_grant_ext);

  // Grant is one-hot, so OR-ing the masked lanes yields the granted source.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_sel_data = w_sel_data | src_data[i*8 +: 8];
    end
  end

  assign w_sel_valid = |(src_valid & r_grant);
  assign w_sel_last  = |(src_last & r_grant);
  assign src_ready   = (r_state == DATA && uart.uart_empty && !r_we) ? r_grant : '0;
  assign w_accept    = w_sel_valid && (r_state == DATA) && uart.uart_empty && !r_we;
  assign w_hit_max   = (r_len_cnt + LEN_W'(1)) == LEN_W'(MAX_LEN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ret      <= IDLE;
      r_grant    <= '0;
      r_len_cnt  <= '0;
      r_overflow <= 1'b0;
      r_we       <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret      <= w_ret_nxt;
      r_grant    <= w_grant_nxt;
      r_len_cnt  <= w_len_nxt;
      r_overflow <= w_ovf_nxt;
      r_we       <= w_we_nxt;
      r_data     <= w_data_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // Every byte strobe detours through GAP so uart_empty can drop before the next byte.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = HDR0;
      HDR0: if (uart.uart_empty) begin
        w_state_nxt = GAP;
        w_ret_nxt   = HDR1;
      end
      HDR1: if (uart.uart_empty) begin
        w_state_nxt = GAP;
        w_ret_nxt   = DATA;
      end
      DATA: if (w_accept) begin
        w_state_nxt = GAP;
        w_ret_nxt   = (w_sel_last || w_hit_max) ? DONE : DATA;
      end
      GAP:     w_state_nxt = r_ret;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = r_grant;
    w_len_nxt   = r_len_cnt;
    w_ovf_nxt   = r_overflow;
    w_we_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_grant_nxt = w_pick;
      HDR0: if (uart.uart_empty) begin
        w_we_nxt   = 1'b1;
        w_data_nxt = SYNC_BYTE;
      end
      HDR1: if (uart.uart_empty) begin
        w_we_nxt   = 1'b1;
        w_data_nxt = {{(8-IDX_W){1'b0}}, w_gidx};
      end
      DATA: if (w_accept) begin
        w_we_nxt   = 1'b1;
        w_data_nxt = w_sel_data;
        w_len_nxt  = r_len_cnt + LEN_W'(1);
        if (!w_sel_last && w_hit_max) w_ovf_nxt = 1'b1;
      end
      DONE: begin
        w_grant_nxt = '0;
        w_len_nxt   = '0;
        w_advance   = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant                = r_grant;
  assign busy                 = r_busy;
  assign overflow             = r_overflow;
  assign uart.uart_tx_data_we = r_we;
  assign uart.uart_tx_data    = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two sources, MAX_LEN=4 so the
// forced-termination path is reachable with short packets.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int MLEN = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] src_data;
  logic [NREQ-1:0]   src_valid;
  logic [NREQ-1:0]   src_last;
  logic [NREQ-1:0]   src_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              overflow;

  uart_tx_arbiter_if uartIf ();

  uart_tx_arbiter #(
    .NUM_REQ   (NREQ),
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MLEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_ready (src_ready),
    .grant     (grant),
    .busy      (busy),
    .overflow  (overflow),
    .uart      (uartIf)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  int cycle      = 0;
  int wideCount  = 0;
  logic prevWe   = 1'b0;

  logic [7:0] strobeQ[$];
  int         stampQ[$];
  logic [7:0] expQ[$];
  logic [8:0] srcQ0[$];
  logic [8:0] srcQ1[$];
  logic [NREQ-1:0] srcHold = '0;
  logic [NREQ-1:0] hsAcc   = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter-side monitor: log every strobe with its cycle stamp.
  always @(negedge clk) begin
    cycle++;
    if (uartIf.uart_tx_data_we === 1'b1) begin
      strobeQ.push_back(uartIf.uart_tx_data);
      stampQ.push_back(cycle);
    end
    if (uartIf.uart_tx_data_we === 1'b1 && prevWe) wideCount++;
    prevWe = (uartIf.uart_tx_data_we === 1'b1);
  end

  always @(posedge clk) hsAcc <= src_valid & src_ready;

  // Source model: present the head of each queue, pop it after a handshake.
  always @(negedge clk) begin
    if (hsAcc[0] === 1'b1 && srcQ0.size() > 0) void'(srcQ0.pop_front());
    if (hsAcc[1] === 1'b1 && srcQ1.size() > 0) void'(srcQ1.pop_front());
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    if (srcQ0.size() > 0 && !srcHold[0]) begin
      src_valid[0]   = 1'b1;
      src_last[0]    = srcQ0[0][8];
      src_data[7:0]  = srcQ0[0][7:0];
    end
    if (srcQ1.size() > 0 && !srcHold[1]) begin
      src_valid[1]   = 1'b1;
      src_last[1]    = srcQ1[0][8];
      src_data[15:8] = srcQ1[0][7:0];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] reqV, input logic emptyV);
    req               = reqV;
    uartIf.uart_empty = emptyV;
  endtask

  task automatic waitStrobes(input string tag, input int n, input int maxCyc);
    int k;
    k = 0;
    while (strobeQ.size() < n && k < maxCyc) begin
      tick();
      k++;
    end
    checkOutput({tag, " strobe count"}, strobeQ.size(), n);
  endtask

  task automatic waitGrant(input string tag, input logic [NREQ-1:0] exp, input int maxCyc);
    int k;
    k = 0;
    while (grant !== exp && k < maxCyc) begin
      tick();
      k++;
    end
    checkOutput({tag, " grant"}, grant, exp);
  endtask

  task automatic waitIdle(input string tag, input int maxCyc);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < maxCyc) begin
      tick();
      k++;
    end
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " grant idle"}, grant, 0);
  endtask

  task automatic checkStrobes(input string tag);
    checkOutput({tag, " stream length"}, strobeQ.size(), expQ.size());
    for (int k = 0; k < expQ.size(); k++) begin
      if (k < strobeQ.size()) begin
        checkOutput($sformatf("%s byte%0d", tag, k), strobeQ[k], expQ[k]);
        if (k > 0) checkOutput($sformatf("%s spacing%0d", tag, k), (stampQ[k] - stampQ[k-1]) >= 2, 1);
      end
    end
    strobeQ.delete();
    stampQ.delete();
    expQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " grant"}, grant, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " overflow"}, overflow, 0);
    checkOutput({tag, " we"}, uartIf.uart_tx_data_we, 0);
    checkOutput({tag, " data"}, uartIf.uart_tx_data, 0);
    checkOutput({tag, " src_ready"}, src_ready, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int badReady;
    int extra;
    int lost;
    logic sawDrop;

    reset_n = 1'b0;
    applyStimulus('0, 1'b1);
    repeat (3) tick();
    checkAllZero("reset");
    reset_n = 1'b1;

    // Single packet from source 0.
    srcQ0.push_back({1'b0, 8'h11});
    srcQ0.push_back({1'b0, 8'h22});
    srcQ0.push_back({1'b1, 8'h33});
    applyStimulus(2'b01, 1'b1);
    tick();
    checkOutput("single grant latency", grant, 2'b01);
    checkOutput("single busy", busy, 1);
    applyStimulus(2'b00, 1'b1);
    waitStrobes("single", 5, 60);
    waitIdle("single", 20);
    expQ = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33};
    checkStrobes("single");

    // Both sources requesting when reset releases.
    reset_n = 1'b0;
    srcQ0.push_back({1'b1, 8'hC1});
    srcQ1.push_back({1'b1, 8'hD1});
    applyStimulus(2'b11, 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    waitGrant("contend first", 2'b01, 5);
    waitGrant("contend second", 2'b10, 40);
    applyStimulus(2'b00, 1'b1);
    waitIdle("contend", 40);
    expQ = '{8'hA5, 8'h00, 8'hC1, 8'hA5, 8'h01, 8'hD1};
    checkStrobes("contend");

    srcQ0.push_back({1'b1, 8'hE1});
    srcQ1.push_back({1'b1, 8'hE2});
    applyStimulus(2'b11, 1'b1);
    waitGrant("wrap first", 2'b01, 5);
    waitGrant("wrap second", 2'b10, 40);
    applyStimulus(2'b00, 1'b1);
    waitIdle("wrap", 40);
    expQ = '{8'hA5, 8'h00, 8'hE1, 8'hA5, 8'h01, 8'hE2};
    checkStrobes("wrap");

    // Transmitter backpressure in mid-payload.
    srcQ0.push_back({1'b0, 8'h41});
    srcQ0.push_back({1'b0, 8'h42});
    srcQ0.push_back({1'b1, 8'h43});
    applyStimulus(2'b01, 1'b1);
    waitGrant("bp", 2'b01, 5);
    applyStimulus(2'b00, 1'b1);
    waitStrobes("bp pre", 3, 30);
    uartIf.uart_empty = 1'b0;
    badReady = 0;
    extra    = 0;
    repeat (20) begin
      tick();
      if (src_ready !== '0) badReady++;
      if (uartIf.uart_tx_data_we !== 1'b0) extra++;
    end
    checkOutput("bp ready held low", badReady, 0);
    checkOutput("bp no strobe", extra, 0);
    checkOutput("bp count held", strobeQ.size(), 3);
    uartIf.uart_empty = 1'b1;
    tick();
    tick();
    checkOutput("bp single strobe after release", strobeQ.size(), 4);
    waitStrobes("bp", 5, 30);
    waitIdle("bp", 20);
    expQ = '{8'hA5, 8'h00, 8'h41, 8'h42, 8'h43};
    checkStrobes("bp");

    // Six bytes without last against MAX_LEN=4.
    for (int b = 1; b <= 6; b++) srcQ0.push_back({1'b0, 8'h50 + 8'(b)});
    applyStimulus(2'b01, 1'b1);
    waitStrobes("ovf first", 6, 60);
    checkOutput("ovf flag", overflow, 1);
    sawDrop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (grant === '0) sawDrop = 1'b1;
    end
    checkOutput("ovf grant drop", sawDrop, 1);
    waitStrobes("ovf regrant", 10, 60);
    checkOutput("ovf sticky", overflow, 1);

    // Reset right after the second payload byte of the re-granted packet.
    reset_n = 1'b0;
    applyStimulus(2'b00, 1'b1);
    tick();
    checkAllZero("midreset");
    reset_n = 1'b1;
    expQ = '{8'hA5, 8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 8'hA5, 8'h00, 8'h55, 8'h56};
    checkStrobes("ovf");

    srcQ0.push_back({1'b1, 8'h61});
    srcQ1.push_back({1'b1, 8'h71});
    applyStimulus(2'b11, 1'b1);
    waitGrant("postreset first", 2'b01, 5);
    waitGrant("postreset second", 2'b10, 40);
    applyStimulus(2'b00, 1'b1);
    waitIdle("postreset", 40);
    expQ = '{8'hA5, 8'h00, 8'h61, 8'hA5, 8'h01, 8'h71};
    checkStrobes("postreset");

    // Granted source stalls, then drops req; the packet must still complete.
    srcHold[1] = 1'b1;
    srcQ1.push_back({1'b0, 8'h81});
    srcQ1.push_back({1'b1, 8'h82});
    applyStimulus(2'b10, 1'b1);
    waitGrant("stall", 2'b10, 5);
    waitStrobes("stall hdr", 2, 20);
    lost = 0;
    repeat (50) begin
      tick();
      if (grant !== 2'b10) lost++;
    end
    applyStimulus(2'b00, 1'b1);
    repeat (5) begin
      tick();
      if (grant !== 2'b10) lost++;
    end
    checkOutput("stall grant held", lost, 0);
    checkOutput("stall no payload", strobeQ.size(), 2);
    checkOutput("stall busy", busy, 1);
    srcHold[1] = 1'b0;
    waitStrobes("stall", 4, 20);
    waitIdle("stall", 20);
    expQ = '{8'hA5, 8'h01, 8'h81, 8'h82};
    checkStrobes("stall");

    checkOutput("strobe width", wideCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter byte interface (uart_tx_data / uart_tx_data_we, uart_empty) between NUM_REQ packet sources, for example the mic capture streamer and the oscilloscope status reporter.
- Arbitration is round-robin at packet granularity.
- Each granted packet is prefixed with a 2-byte header: SYNC_BYTE, then the source index.
- Only one byte is in flight at a time; a byte is written only while uart_empty=1.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SYNC_BYTE, 8'hA5, first header byte of every packet.
- MAX_LEN, 4096, maximum payload bytes per packet before forced termination.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-source packet request, level
- src_data  in  NUM_REQ*8  per-source byte; source i uses bits [8i+7:8i]
- src_valid  in  NUM_REQ  per-source byte valid
- src_last  in  NUM_REQ  marks the final payload byte, qualified by valid
- src_ready  out  NUM_REQ  byte accepted when valid&ready
- grant  out  NUM_REQ  one-hot, registered; high from grant until packet end
- busy  out  1  state != IDLE
- overflow  out  1  sticky; set when a packet hits MAX_LEN without last
- uart_empty  in  1  transmitter idle, may accept a byte
- uart_tx_data_we  out  1  one-cycle write strobe
- uart_tx_data  out  8  byte to transmit, valid while we=1

Behaviour:
- Reset (reset_n=0 at a clk edge) forces the following values from the next cycle:
  - state=IDLE, grant=0, src_ready=0, busy=0, overflow=0
  - uart_tx_data_we=0, uart_tx_data=0, rr_ptr=0, len_cnt=0
- Reset mid-packet aborts immediately. No further strobe is issued; a byte already handed to the UART is not recalled.
- All outputs are registered except src_ready.
- src_ready[i] = (state==DATA) & grant[i] & uart_empty & ~we_pending.
- States:
  - IDLE: if any req, select the first set req starting at rr_ptr and wrapping modulo NUM_REQ. Next cycle: grant one-hot, state=HDR0. Latency is req to grant = 1 cycle.
  - HDR0: when uart_empty, drive data=SYNC_BYTE, we=1 (next cycle), go to GAP with ret=HDR1.
  - HDR1: when uart_empty, drive data={index of grant}, zero-extended to 8 bits, we=1, go to GAP with ret=DATA.
  - DATA: on src_valid[g]&src_ready[g], register the byte, we=1, len_cnt++.
    - If src_last[g]: ret=DONE.
    - Else if len_cnt+1==MAX_LEN: set overflow, ret=DONE.
    - Else: ret=DATA.
  - GAP: exactly one cycle with we=0; absorbs uart_empty update latency. Then go to ret.
  - DONE: grant=0, len_cnt=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE. The next grant can follow 1 cycle later.
- Each byte produces exactly one we pulse, with uart_tx_data stable in that cycle. Minimum byte spacing is 2 cycles.
- req deasserting while granted is ignored. The packet ends only on last or MAX_LEN.
- A granted source with src_valid=0 stalls in DATA indefinitely (no timeout).
- Simultaneous requests are resolved by rr_ptr only. A source that just finished has the lowest priority.
- Requests arriving during a packet wait; they are evaluated in IDLE.
- uart_empty=0 stalls HDR0, HDR1 and DATA without a strobe.
- Header source index for NUM_REQ up to 8 fits in 3 bits; bits [7:3] are 0.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, HDR0, HDR1, DATA, GAP, DONE), SYNC_BYTE default, function rr_pick(req, ptr) returning a one-hot.
- Sub-module rr_arbiter: combinational round-robin pick plus the registered pointer, with an advance input pulsed in DONE. Reusable for the VGA/overlay requesters.

Test Plan:
- Single packet: NUM_REQ=2, uart_empty=1. req[0], bytes 11,22,33, last on 33.
  - Strobes carry A5,00,11,22,33 in that order, each one cycle wide, spaced ≥2 cycles.
  - grant[0] falls after 33; busy returns to 0.
- Contention: req[0] and req[1] both asserted at reset release.
  - Packet order is src0 then src1; header bytes 00 then 01.
  - Re-asserting both again gives src0 next (pointer wrapped).
- Backpressure: hold uart_empty=0 for 20 cycles in mid-payload.
  - No strobe and src_ready=0 throughout.
  - After release, exactly one strobe carrying the next byte.
- Overflow: MAX_LEN=4, source sends 6 bytes with no last.
  - 4 payload bytes sent, overflow=1, grant drops.
  - Source bytes 5–6 wait for the next grant, which begins with A5,idx.
- Reset mid-payload: reset_n=0 for 1 cycle after the second payload byte.
  - All outputs 0 on the next cycle, overflow cleared.
  - A subsequent req starts a fresh packet with A5 from src0 priority.
- Stall and drop: src_valid=0 for 50 cycles, then req deasserted.
  - Grant is held; the packet completes on a later valid+last.
